// File: rtl/aw_addr_decoder.sv
// ---------------------------------------------------------------------------
// aw_addr_decoder
//
// Master-side address-channel front end for the crossbar. An incoming AW (or
// AR) beat passes through a skid buffer into an output register. The address
// is decoded against the slave map on the way into the output register, so
// the one-hot slave select, its binary index and the payload are always
// registered together.
//
// Storage is two beats deep: the output register plus one skid entry. Beats
// leave in strict arrival order with no bubbles.
//
// Optional build macro: ADDR_DECODE_LOWPOWER_EN
//   defined   - payload, o_decode and o_index read as zero whenever o_valid is
//               low, and the skid payload is cleared whenever it empties.
//   undefined - the registers load only when a beat arrives, so the last
//               payload and decode stay visible after the block drains.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_valid/o_in_ready  upstream handshake (AWVALID / AWREADY)
//   i_id, i_addr, i_len, i_attr
//                       upstream payload; i_attr is
//                       {size[3],burst[2],lock,cache[4],prot[3],qos[4]}
//   o_valid/i_ready     downstream handshake (i_ready is slave_awaccepts)
//   o_decode            one-hot slave select; bit NS is the no-slave slot
//   o_index             binary form of o_decode
//   o_id, o_addr, o_len, o_attr
//                       held payload
//   o_busy              a beat is held somewhere in this block
// ---------------------------------------------------------------------------
module aw_addr_decoder #(
    parameter int               NS         = 4,
    parameter int               LGNS       = $clog2(NS + 1),
    parameter int               AW         = 32,
    parameter int               IDW        = 4,
    parameter logic [NS*AW-1:0] SLAVE_ADDR = '0,
    parameter logic [NS*AW-1:0] SLAVE_MASK = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_in_ready,
    input  logic [IDW-1:0]  i_id,
    input  logic [AW-1:0]   i_addr,
    input  logic [7:0]      i_len,
    input  logic [16:0]     i_attr,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [NS:0]     o_decode,
    output logic [LGNS-1:0] o_index,
    output logic [IDW-1:0]  o_id,
    output logic [AW-1:0]   o_addr,
    output logic [7:0]      o_len,
    output logic [16:0]     o_attr,
    output logic            o_busy
);

    // Payload is packed as {id, addr, len, attr}.
    localparam int PW = IDW + AW + 8 + 17;

    logic [PW-1:0]   in_data;
    logic            skid_full_reg;
    logic [PW-1:0]   skid_data_reg;
    logic            out_valid_reg;
    logic [PW-1:0]   out_data_reg;
    logic [NS:0]     out_decode_reg;
    logic [LGNS-1:0] out_index_reg;

    logic            in_ready;
    logic            accept;
    logic            load_out;
    logic            have_beat;
    logic [PW-1:0]   mux_data;
    logic [AW-1:0]   mux_addr;
    logic [NS-1:0]   hit;
    logic [LGNS-1:0] index_next;
    logic [NS:0]     decode_next;

    assign in_data = {i_id, i_addr, i_len, i_attr};

    // Reset forces the upstream ready low.
    assign in_ready = !skid_full_reg && !i_reset;
    assign accept   = i_valid && in_ready;
    assign load_out = !out_valid_reg || i_ready;

    // A full skid entry is always older than anything on the input, so it
    // takes priority on its way into the output register. The input cannot
    // be accepted while the skid entry is full.
    assign mux_data  = skid_full_reg ? skid_data_reg : in_data;
    assign have_beat = skid_full_reg || accept;
    assign mux_addr  = mux_data[PW-IDW-1 -: AW];

    // Per-slave match on the address that is about to be registered.
    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_hit
            assign hit[gi] = ((mux_addr & SLAVE_MASK[gi*AW +: AW]) ==
                              (SLAVE_ADDR[gi*AW +: AW] & SLAVE_MASK[gi*AW +: AW]));
        end
    endgenerate

    // Lowest-numbered matching slave wins. Scanning downwards lets the
    // final assignment belong to the smallest index. With no match the
    // request goes to the error slot NS.
    always_comb begin
        index_next = LGNS'(NS);
        for (int k = NS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                index_next = LGNS'(k);
            end
        end
    end

    // The one-hot select is derived from the index, so it is one-hot by
    // construction.
    generate
        for (genvar gi = 0; gi <= NS; gi++) begin : g_onehot
            assign decode_next[gi] = (index_next == LGNS'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_decode_reg <= '0;
            out_index_reg  <= '0;
            skid_full_reg  <= 1'b0;
            skid_data_reg  <= '0;
        end else begin
            // Output register stage.
            if (load_out) begin
                out_valid_reg <= have_beat;
                if (have_beat) begin
                    out_data_reg   <= mux_data;
                    out_decode_reg <= decode_next;
                    out_index_reg  <= index_next;
                end
`ifdef ADDR_DECODE_LOWPOWER_EN
                else begin
                    out_data_reg   <= '0;
                    out_decode_reg <= '0;
                    out_index_reg  <= '0;
                end
`endif
            end

            // Skid stage. While full it drains into the output register as
            // soon as that register frees up. While empty it catches an
            // accepted beat that cannot reach the stalled output register.
            if (skid_full_reg) begin
                if (load_out) begin
                    skid_full_reg <= 1'b0;
`ifdef ADDR_DECODE_LOWPOWER_EN
                    skid_data_reg <= '0;
`endif
                end
            end else if (accept && out_valid_reg && !i_ready) begin
                skid_full_reg <= 1'b1;
                skid_data_reg <= in_data;
            end
        end
    end

    assign o_in_ready = in_ready;
    assign o_valid    = out_valid_reg;
    assign o_decode   = out_decode_reg;
    assign o_index    = out_index_reg;
    assign o_id       = out_data_reg[PW-1 -: IDW];
    assign o_addr     = out_data_reg[PW-IDW-1 -: AW];
    assign o_len      = out_data_reg[24:17];
    assign o_attr     = out_data_reg[16:0];
    assign o_busy     = out_valid_reg || skid_full_reg;

endmodule

// File: tb/tb_aw_addr_decoder.sv
// ---------------------------------------------------------------------------
// tb_aw_addr_decoder
//
// Two decoders share the same stimulus. dut_a uses the two-slave map
// (0x0xxx_xxxx, 0x1xxx_xxxx). dut_b uses the same bases with all-zero masks,
// so every slave matches.
//
// The reference model treats the block as a queue holding at most two beats:
//   - a beat is pushed when valid and fewer than two beats are held;
//   - the head is popped when ready;
//   - the head is the visible output.
// Decode is computed directly from the address rules.
// ---------------------------------------------------------------------------
module tb_aw_addr_decoder;

    localparam int NS   = 2;
    localparam int LGNS = 2;
    localparam int AW   = 32;
    localparam int IDW  = 4;

    localparam logic [NS*AW-1:0] BASES   = {32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASKS_A = {32'hF000_0000, 32'hF000_0000};
    localparam logic [NS*AW-1:0] MASKS_B = '0;

    logic           clk = 1'b0;
    logic           i_reset;
    logic           i_valid;
    logic           i_ready;
    logic [IDW-1:0] i_id;
    logic [AW-1:0]  i_addr;
    logic [7:0]     i_len;
    logic [16:0]    i_attr;

    logic            a_in_ready, a_valid, a_busy;
    logic [NS:0]     a_decode;
    logic [LGNS-1:0] a_index;
    logic [IDW-1:0]  a_id;
    logic [AW-1:0]   a_addr;
    logic [7:0]      a_len;
    logic [16:0]     a_attr;

    logic            b_in_ready, b_valid, b_busy;
    logic [NS:0]     b_decode;
    logic [LGNS-1:0] b_index;
    logic [IDW-1:0]  b_id;
    logic [AW-1:0]   b_addr;
    logic [7:0]      b_len;
    logic [16:0]     b_attr;

    aw_addr_decoder #(
        .NS(NS), .LGNS(LGNS), .AW(AW), .IDW(IDW),
        .SLAVE_ADDR(BASES), .SLAVE_MASK(MASKS_A)
    ) dut_a (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_in_ready(a_in_ready),
        .i_id(i_id), .i_addr(i_addr), .i_len(i_len), .i_attr(i_attr),
        .o_valid(a_valid), .i_ready(i_ready), .o_decode(a_decode), .o_index(a_index),
        .o_id(a_id), .o_addr(a_addr), .o_len(a_len), .o_attr(a_attr), .o_busy(a_busy)
    );

    aw_addr_decoder #(
        .NS(NS), .LGNS(LGNS), .AW(AW), .IDW(IDW),
        .SLAVE_ADDR(BASES), .SLAVE_MASK(MASKS_B)
    ) dut_b (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_in_ready(b_in_ready),
        .i_id(i_id), .i_addr(i_addr), .i_len(i_len), .i_attr(i_attr),
        .o_valid(b_valid), .i_ready(i_ready), .o_decode(b_decode), .o_index(b_index),
        .o_id(b_id), .o_addr(b_addr), .o_len(b_len), .o_attr(b_attr), .o_busy(b_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [16:0]    attr;
    } beat_t;

    beat_t        q[$];
    logic [AW-1:0] last_addr;
    bit           have_last = 0;
    bit           chk_en    = 0;
    int           hs_cnt    = 0;

    // Index of the first matching slave, or NS when nothing matches.
    function automatic int exp_index(input logic [31:0] a, input logic [NS*AW-1:0] masks);
        for (int k = 0; k < NS; k++) begin
            if ((a & masks[k*AW +: AW]) == (BASES[k*AW +: AW] & masks[k*AW +: AW])) return k;
        end
        return NS;
    endfunction

    always @(posedge clk) begin
        if (i_reset) begin
            q.delete();
            have_last = 0;
        end else begin
            // Push eligibility is decided on the occupancy before any pop.
            bit push;
            beat_t b;
            push   = i_valid && (q.size() < 2);
            b.id   = i_id;
            b.addr = i_addr;
            b.len  = i_len;
            b.attr = i_attr;
            if (q.size() > 0 && i_ready) begin
                last_addr = q[0].addr;
                have_last = 1;
                void'(q.pop_front());
                hs_cnt++;
            end
            if (push) q.push_back(b);
        end
    end

    // One compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int  n;
            bit  ex_ready;
            n        = q.size();
            ex_ready = !i_reset && (n < 2);
            chk("a_in_ready", 32'(a_in_ready), 32'(ex_ready));
            chk("b_in_ready", 32'(b_in_ready), 32'(ex_ready));
            chk("a_valid",    32'(a_valid),    32'(n > 0));
            chk("b_valid",    32'(b_valid),    32'(n > 0));
            chk("a_busy",     32'(a_busy),     32'(n > 0));
            chk("b_busy",     32'(b_busy),     32'(n > 0));
            if (n > 0) begin
                int ia, ib;
                ia = exp_index(q[0].addr, MASKS_A);
                ib = exp_index(q[0].addr, MASKS_B);
                chk("a_id",     32'(a_id),     32'(q[0].id));
                chk("a_addr",   a_addr,        q[0].addr);
                chk("a_len",    32'(a_len),    32'(q[0].len));
                chk("a_attr",   32'(a_attr),   32'(q[0].attr));
                chk("a_index",  32'(a_index),  32'(ia));
                chk("a_decode", 32'(a_decode), 32'(1) << ia);
                chk("b_id",     32'(b_id),     32'(q[0].id));
                chk("b_addr",   b_addr,        q[0].addr);
                chk("b_len",    32'(b_len),    32'(q[0].len));
                chk("b_attr",   32'(b_attr),   32'(q[0].attr));
                chk("b_index",  32'(b_index),  32'(ib));
                chk("b_decode", 32'(b_decode), 32'(1) << ib);
            end else begin
`ifdef ADDR_DECODE_LOWPOWER_EN
                chk("a_idle_addr",   a_addr,          32'h0);
                chk("a_idle_decode", 32'(a_decode),   32'h0);
                chk("a_idle_index",  32'(a_index),    32'h0);
                chk("b_idle_id",     32'(b_id),       32'h0);
`else
                if (have_last) chk("a_idle_addr", a_addr, last_addr);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] id, input logic [31:0] addr);
        i_valid = v;
        i_id    = id;
        i_addr  = addr;
        i_len   = 8'(id) + 8'h10;
        i_attr  = 17'(addr[16:0]) ^ 17'h0A5A5;
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        while (a_busy && guard < 20) begin
            tick();
            guard++;
        end
        chk(nm, 32'(a_busy), 32'h0);
    endtask

    initial begin
        int sent;
        int guard;
        bit acc;

        i_reset = 1'b1;
        i_ready = 1'b0;
        drive(1'b0, 4'h0, 32'h0);
        tick();
        chk_en = 1;

        // Reset state.
        chk("rst_in_ready", 32'(a_in_ready), 32'h0);
        chk("rst_valid",    32'(a_valid),    32'h0);
        chk("rst_decode",   32'(a_decode),   32'h0);
        chk("rst_index",    32'(a_index),    32'h0);
        chk("rst_busy",     32'(a_busy),     32'h0);
        tick();
        i_reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(a_in_ready), 32'h1);

        // Plan 1: single beat to slave 1.
        i_ready = 1'b1;
        drive(1'b1, 4'd3, 32'h1000_0040);
        tick();
        drive(1'b0, 4'd0, 32'h0);
        chk("t1_valid",    32'(a_valid),  32'h1);
        chk("t1_decode",   32'(a_decode), 32'b010);
        chk("t1_index",    32'(a_index),  32'h1);
        chk("t1_id",       32'(a_id),     32'h3);
        chk("t1_b_decode", 32'(b_decode), 32'b001);

        // Plan 2: no slave matches, so the error slot is selected.
        drive(1'b1, 4'd9, 32'h2000_0000);
        tick();
        drive(1'b0, 4'd0, 32'h0);
        chk("t2_decode",   32'(a_decode), 32'b100);
        chk("t2_index",    32'(a_index),  32'h2);
        chk("t2_b_decode", 32'(b_decode), 32'b001);
        chk("t2_b_index",  32'(b_index),  32'h0);
        tick();

        // Plan 3: fill both stages while stalled, then release.
        i_ready = 1'b0;
        drive(1'b1, 4'd4, 32'h0000_0100);
        tick();
        drive(1'b1, 4'd5, 32'h1000_0200);
        tick();
        chk("t3_full_ready", 32'(a_in_ready), 32'h0);
        chk("t3_hold_a",     32'(a_id),       32'h4);
        drive(1'b1, 4'd6, 32'h2000_0300);
        tick();
        tick();
        chk("t3_still_a", 32'(a_id),   32'h4);
        chk("t3_still_ad", a_addr,     32'h0000_0100);
        i_ready = 1'b1;
        tick();
        chk("t3_b_out", 32'(a_id), 32'h5);
        tick();
        chk("t3_c_out", 32'(a_id), 32'h6);
        drive(1'b0, 4'd0, 32'h0);
        tick();
        chk("t3_empty", 32'(a_valid), 32'h0);

        // Plan 4: 16 beats with ready toggling every cycle.
        hs_cnt = 0;
        sent   = 0;
        guard  = 0;
        while (sent < 16 && guard < 200) begin
            i_ready = guard[0];
            drive(1'b1, 4'(sent), {4'(sent % 3), 20'h0, 8'(sent)});
            acc = a_in_ready;
            tick();
            if (acc) sent++;
            guard++;
        end
        chk("t4_sent", 32'(sent), 32'd16);
        drain("t4_drain");
        chk("t4_handshakes", 32'(hs_cnt), 32'd16);

        // Plan 5: reset while both stages are full.
        i_ready = 1'b0;
        drive(1'b1, 4'd1, 32'h0000_0AAA);
        tick();
        drive(1'b1, 4'd2, 32'h1000_0BBB);
        tick();
        drive(1'b0, 4'd0, 32'h0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        chk("t5_valid",    32'(a_valid),    32'h0);
        chk("t5_busy",     32'(a_busy),     32'h0);
        chk("t5_in_ready", 32'(a_in_ready), 32'h1);

        // Plan 6: idle output contents after the block drains.
        i_ready = 1'b1;
        drive(1'b1, 4'd7, 32'h0000_0ABC);
        tick();
        drive(1'b0, 4'd0, 32'h0);
        tick();
        tick();
`ifdef ADDR_DECODE_LOWPOWER_EN
        chk("t6_addr",   a_addr,          32'h0);
        chk("t6_decode", 32'(a_decode),   32'h0);
`else
        chk("t6_addr",   a_addr,          32'h0000_0ABC);
`endif

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            i_reset = ($urandom_range(0, 63) == 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_valid = ($urandom_range(0, 3) != 0);
            i_id    = 4'($urandom);
            i_addr  = {4'($urandom_range(0, 3)), 28'($urandom)};
            i_len   = 8'($urandom);
            i_attr  = 17'($urandom);
            tick();
        end
        i_reset = 1'b0;
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
